// File: rtl/lv2_mem_arbiter_pkg.sv
// lv2_arb_pkg: shared types and constants for the lv2 memory-port arbiter.
//   arb_state_t     : transaction sequencer states IDLE/ISSUE/WAIT/RESP
//   arb_op_t        : latched operation of the current transaction
//   DEFAULT_TIMEOUT : default WAIT watchdog limit (LV2_ARB_TIMEOUT_EN builds)
//   onehot_to_idx   : index of the set bit of a one-hot grant (up to 8 requesters)
// Default bus widths are supplied here when the build does not define them.
`ifndef DATA_WID_LV2
`define DATA_WID_LV2 32
`endif
`ifndef ADDR_WID_LV2
`define ADDR_WID_LV2 16
`endif

package lv2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

    localparam int DEFAULT_TIMEOUT = 16;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lv2_mem_arbiter_if.sv
// lv2_mem_arbiter_if: requester-side and memory-side control signals of the
// lv2 memory arbiter. The bidirectional data bus stays a plain inout port
// of the arbiter so the tri-state net is resolved at the top level.
//   modport master : the arbiter (consumes requests / handshakes, drives grants,
//                    completion, read data and memory strobes)
//   modport slave  : the environment (requesters and memory)
`ifndef DATA_WID_LV2
`define DATA_WID_LV2 32
`endif
`ifndef ADDR_WID_LV2
`define ADDR_WID_LV2 16
`endif

interface lv2_mem_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_WID = `DATA_WID_LV2,
    parameter int ADDR_WID = `ADDR_WID_LV2
);
    logic [NUM_REQ-1:0]          req_rd;
    logic [NUM_REQ-1:0]          req_wr;
    logic [NUM_REQ*ADDR_WID-1:0] req_addr;
    logic [NUM_REQ*DATA_WID-1:0] req_wdata;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          done;
    logic [DATA_WID-1:0]         rdata;
    logic                        err;
    logic [ADDR_WID-1:0]         addr_bus_lv2_mem;
    logic                        mem_rd;
    logic                        mem_wr;
    logic                        data_in_bus_lv2_mem;
    logic                        mem_wr_done;

    modport master (
        input  req_rd, req_wr, req_addr, req_wdata,
        input  data_in_bus_lv2_mem, mem_wr_done,
        output gnt, done, rdata, err,
        output addr_bus_lv2_mem, mem_rd, mem_wr
    );

    modport slave (
        output req_rd, req_wr, req_addr, req_wdata,
        output data_in_bus_lv2_mem, mem_wr_done,
        input  gnt, done, rdata, err,
        input  addr_bus_lv2_mem, mem_rd, mem_wr
    );
endinterface

// File: rtl/lv2_mem_arbiter_chk.sv
// lv2_mem_arbiter_chk: protocol checker for the arbiter's memory strobes.
//   clk, rst       : arbiter clock and reset
//   mem_rd, mem_wr : memory strobes; each is a single-cycle pulse per
//                    transaction and the two are never high together
module lv2_mem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic mem_rd,
    input logic mem_wr
);

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_rd && mem_wr));
    a_rd_pulse:    assert property (@(posedge clk) disable iff (rst) mem_rd |=> !mem_rd);
    a_wr_pulse:    assert property (@(posedge clk) disable iff (rst) mem_wr |=> !mem_wr);

endmodule

// File: rtl/lv2_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   i_req : request vector, one bit per requester
//   i_ptr : requester with highest priority this round
//   o_gnt : one-hot winner (all zero when nothing requests)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Scan requesters starting at the pointer, wrapping; first hit wins.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/lv2_mem_arbiter.sv
// lv2_mem_arbiter: shares one lv2<->memory port between NUM_REQ requesters.
// Round-robin arbitration, one transaction at a time, sequenced as
// IDLE -> ISSUE (one-cycle mem_rd/mem_wr strobe) -> WAIT (memory handshake)
// -> RESP (one-cycle done to the owner). All outputs are registered.
// Ports:
//   clk, rst          : clock (posedge), asynchronous active-high reset
//   bus (master)      : req_rd/req_wr/req_addr/req_wdata in, gnt/done/rdata/err
//                       out, addr_bus_lv2_mem/mem_rd/mem_wr out,
//                       data_in_bus_lv2_mem/mem_wr_done in
//   data_bus_lv2_mem  : bidirectional data, driven only in ISSUE of a write
// Build option: define LV2_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT_CYC cycles;
// expiry completes the transaction with err=1 and rdata=0. Without it WAIT is
// unbounded and err is constant 0.
`ifndef DATA_WID_LV2
`define DATA_WID_LV2 32
`endif
`ifndef ADDR_WID_LV2
`define ADDR_WID_LV2 16
`endif

module lv2_mem_arbiter
    import lv2_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WID    = `DATA_WID_LV2,
    parameter int ADDR_WID    = `ADDR_WID_LV2,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    lv2_mem_arbiter_if.master   bus,
    inout  wire  [DATA_WID-1:0] data_bus_lv2_mem
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          r_state;
    arb_op_t             r_op;
    logic [PTR_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [DATA_WID-1:0] r_rdata;
    logic [ADDR_WID-1:0] r_addr;
    logic [DATA_WID-1:0] r_wdata;
    logic                r_drive;
    logic                r_mem_rd;
    logic                r_mem_wr;

    logic [NUM_REQ-1:0]  w_req;
    logic [NUM_REQ-1:0]  w_win;
    logic [PTR_W-1:0]    w_win_idx;

`ifdef LV2_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
`endif

    assign w_req     = bus.req_rd | bus.req_wr;
    assign w_win_idx = PTR_W'(onehot_to_idx(8'(w_win)));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_win)
    );

    assign bus.gnt              = r_gnt;
    assign bus.done             = r_done;
    assign bus.rdata            = r_rdata;
    assign bus.addr_bus_lv2_mem = r_addr;
    assign bus.mem_rd           = r_mem_rd;
    assign bus.mem_wr           = r_mem_wr;
    assign data_bus_lv2_mem     = r_drive ? r_wdata : {DATA_WID{1'bz}};
`ifdef LV2_ARB_TIMEOUT_EN
    assign bus.err              = r_err;
`else
    assign bus.err              = 1'b0;
`endif

    // Transaction sequencer: arbitration, strobe generation, handshake wait, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_RD;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_drive  <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
`ifdef LV2_ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_gnt   <= w_win;
                        r_addr  <= bus.req_addr[w_win_idx*ADDR_WID +: ADDR_WID];
                        r_wdata <= bus.req_wdata[w_win_idx*DATA_WID +: DATA_WID];
                        // rd and wr together resolve to a write
                        r_op     <= bus.req_wr[w_win_idx] ? OP_WR : OP_RD;
                        r_mem_wr <= bus.req_wr[w_win_idx];
                        r_mem_rd <= ~bus.req_wr[w_win_idx];
                        r_drive  <= bus.req_wr[w_win_idx];
                        if (w_win_idx == PTR_W'(NUM_REQ - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= w_win_idx + 1'b1;
                        end
                        r_state <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_drive  <= 1'b0;
`ifdef LV2_ARB_TIMEOUT_EN
                    r_cnt    <= '0;
`endif
                    r_state  <= WAIT;
                end
                WAIT: begin
                    if ((r_op == OP_RD) && bus.data_in_bus_lv2_mem) begin
                        r_rdata <= data_bus_lv2_mem;
                        r_done  <= r_gnt;
                        r_state <= RESP;
                    end else if ((r_op == OP_WR) && bus.mem_wr_done) begin
                        r_done  <= r_gnt;
                        r_state <= RESP;
`ifdef LV2_ARB_TIMEOUT_EN
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_done  <= r_gnt;
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
`else
                    end else begin
                        r_state <= WAIT;
                    end
`endif
                end
                RESP: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
`ifdef LV2_ARB_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= IDLE;
                end
                default: begin
                    r_done   <= '0;
                    r_gnt    <= '0;
                    r_drive  <= 1'b0;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
